// File: rtl/countdown_timer.sv
// Loadable down-counter that raises a one-cycle tick on expiry, in periodic
// or one-shot mode, with pause/resume and an 8-bit tick counter.
module countdown_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             start,
    input  logic             pause,
    input  logic             oneshot,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             oneshot_q,  oneshot_d;
    logic             tick_q,     tick_d;
    logic             done_q,     done_d;
    logic [7:0]       tick_cnt_q, tick_cnt_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        oneshot_d  = oneshot_q;
        tick_d     = 1'b0;
        done_d     = done_q;
        tick_cnt_d = tick_cnt_q;

        // load preempts everything, including start and pause in the same cycle
        if (load) begin
            period_d   = period;
            count_d    = period;
            state_d    = S_IDLE;
            done_d     = 1'b0;
            tick_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count_d   = period_q;
                        oneshot_d = oneshot;
                        done_d    = 1'b0;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (count_q != '0) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        tick_d     = 1'b1;
                        tick_cnt_d = tick_cnt_q + 8'd1;
                        if (oneshot_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            count_d = period_q;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            period_q   <= '0;
            oneshot_q  <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            oneshot_q  <= oneshot_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_PAUSED);
    end

    assign tick     = tick_q;
    assign count    = count_q;
    assign done     = done_q;
    assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven checks for countdown_timer plus hand-written
// sequences for tick_cnt wrap, load preemption and asynchronous reset.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 24;

    logic             clock;
    logic             resetn;
    logic             load;
    logic [WIDTH-1:0] period;
    logic             start;
    logic             pause;
    logic             oneshot;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [7:0]       tick_cnt;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .period   (period),
        .start    (start),
        .pause    (pause),
        .oneshot  (oneshot),
        .tick     (tick),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tick_cnt (tick_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit ld;
        int per;
        bit st;
        bit pa;
        bit os;
        bit e_tick;
        int e_cnt;
        bit e_busy;
        bit e_done;
        int e_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit ld, int per, bit st, bit pa, bit os,
                                bit et, int ec, bit eb, bit ed, int etc);
        vec_t v;
        v.ld = ld; v.per = per; v.st = st; v.pa = pa; v.os = os;
        v.e_tick = et; v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = etc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit et, input int ec,
                           input bit eb, input bit ed, input int etc);
        chk({tag, ".tick"},     32'(tick),     32'(et));
        chk({tag, ".count"},    32'(count),    32'(ec));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".done"},     32'(done),     32'(ed));
        chk({tag, ".tick_cnt"}, 32'(tick_cnt), 32'(etc));
    endtask

    // Drive inputs, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input bit ld, input int per, input bit st, input bit pa, input bit os);
        load    = ld;
        period  = WIDTH'(per);
        start   = st;
        pause   = pa;
        oneshot = os;
        @(posedge clock);
        #1;
    endtask

    initial begin
        load = 0; period = '0; start = 1; pause = 0; oneshot = 0;
        resetn = 0;
        #3;
        chk_all("reset_async", 0, 0, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all("reset_held_start", 0, 0, 0, 0, 0);
        start  = 0;
        resetn = 1;

        // Idle after reset: only load/start act.
        add(0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,1,0, 0,0,0,0,0);
        // period_reg=0 one-shot: tick after one edge, then DONE.
        add(0,0,1,0,1, 0,0,1,0,0);
        add(0,0,0,0,0, 1,0,0,1,1);
        add(0,0,0,0,0, 0,0,0,1,1);
        // Periodic period 3; load clears done and tick_cnt.
        add(1,3,0,0,0, 0,3,0,0,0);
        add(0,0,1,0,0, 0,3,1,0,0);
        add(0,0,0,0,0, 0,2,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0,0, 1,3,1,0,1);
        add(0,0,1,0,1, 0,2,1,0,1);   // start during RUN ignored, mode kept
        add(0,0,0,0,0, 0,1,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 1,3,1,0,2);
        add(0,0,0,0,0, 0,2,1,0,2);
        add(0,0,0,0,0, 0,1,1,0,2);
        add(0,0,0,0,0, 0,0,1,0,2);
        add(0,0,0,0,0, 1,3,1,0,3);
        // One-shot period 2; load beats simultaneous start/pause.
        add(1,2,1,1,1, 0,2,0,0,0);
        add(0,0,1,0,1, 0,2,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0,0, 1,0,0,1,1);
        add(0,0,0,0,0, 0,0,0,1,1);
        add(0,9,1,0,1, 0,2,1,0,1);   // restart from DONE uses period_reg
        add(0,0,0,0,0, 0,1,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 1,0,0,1,2);
        // Pause at count=1 for 4 edges delays the tick by 5.
        add(1,5,0,0,0, 0,5,0,0,0);
        add(0,0,1,0,0, 0,5,1,0,0);
        add(0,0,0,0,0, 0,4,1,0,0);
        add(0,0,0,0,0, 0,3,1,0,0);
        add(0,0,0,0,0, 0,2,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,1,0, 0,1,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0,0, 1,5,1,0,1);
        // Pause wins over count==0.
        add(0,0,0,0,0, 0,4,1,0,1);
        add(0,0,0,0,0, 0,3,1,0,1);
        add(0,0,0,0,0, 0,2,1,0,1);
        add(0,0,0,0,0, 0,1,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,1,0, 0,0,1,0,1);
        add(0,0,0,0,0, 0,0,1,0,1);
        add(0,0,0,0,0, 1,5,1,0,2);
        // start+pause in IDLE: start taken, pause seen next edge.
        add(1,2,0,0,0, 0,2,0,0,0);
        add(0,0,1,1,0, 0,2,1,0,0);
        add(0,0,0,1,0, 0,2,1,0,0);
        add(0,0,0,0,0, 0,2,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].per, vecs[i].st, vecs[i].pa, vecs[i].os);
            chk_all($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_cnt,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_tc);
        end

        // period 0 periodic: tick every cycle, tick_cnt wraps after 256.
        step(1,0,0,0,0);
        chk_all("wrap_load", 0, 0, 0, 0, 0);
        step(0,0,1,0,0);
        chk_all("wrap_start", 0, 0, 1, 0, 0);
        for (int i = 1; i <= 256; i++) begin
            step(0,0,0,0,0);
            chk($sformatf("wrap%0d.tick", i), 32'(tick), 32'd1);
            chk($sformatf("wrap%0d.tick_cnt", i), 32'(tick_cnt), 32'(i % 256));
        end
        step(1,7,1,0,0);
        chk_all("preempt_load", 0, 7, 0, 0, 0);

        // Reset one cycle before a tick aborts with no tick.
        step(1,1,0,0,0);
        step(0,0,1,0,0);
        chk_all("rst_run1", 0, 1, 1, 0, 0);
        step(0,0,0,0,0);
        chk_all("rst_run0", 0, 0, 1, 0, 0);
        #2;
        resetn = 0;
        #1;
        chk_all("rst_mid_async", 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        chk_all("rst_mid_edge", 0, 0, 0, 0, 0);
        resetn = 1;
        step(0,0,0,0,0);
        chk_all("rst_after1", 0, 0, 0, 0, 0);
        step(0,0,0,0,0);
        chk_all("rst_after2", 0, 0, 0, 0, 0);
        step(0,0,1,0,0);
        chk_all("rst_restart", 0, 0, 1, 0, 0);
        step(0,0,0,0,0);
        chk_all("rst_restart_tick", 1, 0, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 24, giving the counter and period width in bits.
REQ-002 The module SHALL have port clock, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1, an asynchronous active-low reset.
REQ-004 The module SHALL have port load, input, 1, which loads the period when high at a clock edge.
REQ-005 The module SHALL have port period, input, WIDTH, the reload value captured on load.
REQ-006 The module SHALL have port start, input, 1, which begins counting from IDLE or DONE.
REQ-007 The module SHALL have port pause, input, 1, a level-sensitive hold of the count while running.
REQ-008 The module SHALL have port oneshot, input, 1, selecting the mode, sampled only on an accepted start: 1 = single tick, 0 = periodic.
REQ-009 The module SHALL have port tick, output, 1, a registered one-cycle expiry pulse.
REQ-010 The module SHALL have port count, output, WIDTH, the current remaining count.
REQ-011 The module SHALL have port busy, output, 1, which is high in the RUN or PAUSED state.
REQ-012 The module SHALL have port done, output, 1, a sticky flag indicating one-shot completion.
REQ-013 The module SHALL have port tick_cnt, output, 8, the number of ticks since the last load or reset, modulo 256.

Function
REQ-014 The module SHALL implement states IDLE, RUN, PAUSED and DONE, plus internal registers period_reg (WIDTH bits) and oneshot_reg.
REQ-015 load SHALL have highest priority in every state: period_reg<=period, count<=period, state<=IDLE, done<=0, tick_cnt<=0, tick<=0; start and pause are ignored in that cycle.
REQ-016 start in IDLE or DONE SHALL set count<=period_reg, oneshot_reg<=oneshot, done<=0 and state<=RUN; start in RUN or PAUSED SHALL be ignored.
REQ-017 In RUN with pause=0 and count!=0, the module SHALL set count<=count-1 and tick<=0.
REQ-018 In RUN with pause=0 and count==0, the module SHALL set tick<=1 and tick_cnt<=tick_cnt+1, wrapping from 255 to 0.
REQ-019 After a tick in periodic mode (oneshot_reg=0), the module SHALL set count<=period_reg and remain in RUN.
REQ-020 After a tick in one-shot mode (oneshot_reg=1), count SHALL stay 0, done SHALL be set to 1, and the state SHALL move to DONE.
REQ-021 The tick period SHALL be period_reg+1 clock edges; the first tick SHALL be high in the cycle following the (period_reg+1)th edge after the start edge.
REQ-022 With period_reg=0 in periodic mode, tick SHALL be high on every cycle from the second edge after start.
REQ-023 In RUN with pause=1, the state SHALL move to PAUSED and count SHALL hold; pause SHALL win over count==0, so no tick is generated in that cycle.
REQ-024 In PAUSED, count SHALL hold and tick SHALL be 0; pause=0 SHALL return the state to RUN, with decrementing resuming on the following edge.
REQ-025 If start and pause are both high in IDLE, start SHALL be taken (RUN), and pause SHALL be evaluated from the next edge.
REQ-026 tick SHALL be 0 in every cycle not described in REQ-018.
REQ-027 busy SHALL be decoded combinationally from the state register.
REQ-028 done SHALL hold at 1 until the next accepted start, a load, or reset.

Reset
REQ-029 While resetn=0, the module SHALL asynchronously force state=IDLE, count=0, period_reg=0, oneshot_reg=0, tick=0, done=0 and tick_cnt=0, with busy therefore 0.
REQ-030 Reset asserted mid-RUN or mid-PAUSED SHALL abort immediately with no tick generated.
REQ-031 After reset deasserts, the module SHALL act only on load or start at subsequent edges.

Verification
REQ-032 Reset: assert resetn=0 with start=1 -> all outputs 0 and state IDLE; after release, start with period_reg=0 and oneshot=1 -> tick after 1 edge, then done=1.
REQ-033 Periodic: load period=3, then start with oneshot=0 -> count sequence 3,2,1,0, tick every 4 cycles, tick_cnt 1,2,3; busy=1 throughout.
REQ-034 One-shot: load 2, then start with oneshot=1 -> a single tick on the 3rd edge, then done=1, busy=0, count=0; a second start -> done clears and a new run begins.
REQ-035 Pause: periodic period=5, hold pause for 4 cycles at count=1 -> count stays 1, no tick; the tick is delayed by exactly 4 cycles (plus 1 cycle of resume).
REQ-036 Wrap and preempt: period=0 periodic, 256 ticks -> tick_cnt wraps to 0; a load of 7 during RUN -> IDLE, count=7, tick_cnt=0, tick=0 on the next cycle.
REQ-037 Ignored start: start pulsed during RUN -> count sequence unaffected and oneshot_reg unchanged.
